frame_tx_sequencer: RTL and testbench
=====================================

FRAME_TX_SEQUENCER -- requirements
Module: frame_tx_sequencer

Interface
REQ-001 Parameter ADDR_W, default 15: frame-buffer read-address width.
REQ-002 Parameter BYTES_PER_FRAME, default 6144: payload bytes per frame, legal range 1..2^ADDR_W.
REQ-003 Parameter GUARD_CYCLES, default 62500: Clk cycles between VS rising edge and the first transmitted byte.
REQ-004 Parameter GAP_CYCLES, default 0: idle Clk cycles inserted after each accepted byte.
REQ-005 Parameter SYNC_LEN, default 2 (0..4): header bytes sent before payload, each of value SYNC_BYTE.
REQ-006 Parameter SYNC_BYTE, default 8'hA5: header byte value.
REQ-007 Clk  in  1: single clock; all logic on its rising edge.
REQ-008 i_Rst_n  in  1: reset, synchronous and active-low.
REQ-009 i_VS  in  1: camera vertical sync, asynchronous to Clk.
REQ-010 i_Enable  in  1: level; high permits starting a new frame.
REQ-011 i_Mem_Data  in  8: frame-buffer read data, valid one cycle after o_Mem_Addr.
REQ-012 i_Tx_Ready  in  1: UART transmitter can accept a byte.
REQ-013 o_Mem_Addr  out  ADDR_W: frame-buffer read address.
REQ-014 o_Capture_En  out  1: high allows the camera reader to write the buffer.
REQ-015 o_Tx_Data  out  8, o_Tx_Valid  out  1: byte offer to the UART.
REQ-016 o_Busy  out  1, o_Frame_Done  out  1, o_Frame_Count  out  8: status.

Function
REQ-017 i_VS SHALL pass a 2-flop synchroniser; rise/fall SHALL be detected on the synchronised value (2-3 cycle detection latency).
REQ-018 States SHALL be IDLE, GUARD, SYNC, FETCH, SEND, GAP, DRAIN.
REQ-019 IDLE: o_Capture_En=1, o_Busy=0; on VS rise with i_Enable=1 -> GUARD, o_Capture_En=0 next cycle, counter cleared.
REQ-020 GUARD: count GUARD_CYCLES cycles, then -> SYNC if SYNC_LEN>0 else FETCH; GUARD_CYCLES=0 SHALL exit after one cycle.
REQ-021 SYNC: offer SYNC_BYTE SYNC_LEN times via the handshake, then -> FETCH.
REQ-022 FETCH: drive o_Mem_Addr, wait one cycle, register i_Mem_Data into o_Tx_Data, -> SEND.
REQ-023 Handshake: a transfer occurs in a cycle where o_Tx_Valid=1 and i_Tx_Ready=1; o_Tx_Data SHALL stay stable while o_Tx_Valid=1 and no transfer; o_Tx_Valid SHALL drop the cycle after a transfer.
REQ-024 After each payload transfer: GAP if GAP_CYCLES>0 (count exactly GAP_CYCLES cycles), then FETCH with address+1; after byte BYTES_PER_FRAME-1 -> DRAIN, address reset to 0.
REQ-025 DRAIN: o_Frame_Done pulses 1 cycle on entry, o_Frame_Count increments mod 256 (255->0); on VS fall -> IDLE.
REQ-026 VS fall already seen during frame SHALL be remembered so DRAIN exits immediately; VS rises outside IDLE SHALL be ignored.
REQ-027 i_Enable low SHALL not abort a frame in progress; it only blocks the IDLE->GUARD transition.
REQ-028 o_Capture_En SHALL be 0 in every state except IDLE; o_Busy SHALL be 1 in every state except IDLE.
REQ-029 Counters SHALL be sized ceil(log2(max(GUARD_CYCLES,GAP_CYCLES)+1)) bits, no overflow.

Reset
REQ-030 i_Rst_n=0 at a rising edge, in any state including mid-SEND, SHALL force IDLE next cycle: o_Mem_Addr=0, o_Tx_Valid=0, o_Tx_Data=0, o_Capture_En=1, o_Busy=0, o_Frame_Done=0, o_Frame_Count=0, synchroniser and VS-fall flag cleared.

Verification
REQ-031 Defaults reduced (BYTES_PER_FRAME=4, GUARD_CYCLES=10, SYNC_LEN=2), i_Tx_Ready=1, VS pulse -> bytes A5,A5,M[0..3] on o_Tx_Data, o_Frame_Count=1, o_Capture_En=0 from 1st cycle after detection until VS fall.
REQ-032 i_Tx_Ready toggled pseudo-randomly -> each byte held stable while stalled, no byte lost or duplicated, address sequence 0,1,2,3.
REQ-033 GAP_CYCLES=5 -> exactly 5 idle cycles between each transfer and next o_Tx_Valid assertion after FETCH.
REQ-034 i_Rst_n low during third payload byte -> all outputs at reset values next cycle; next VS pulse sends full frame from address 0.
REQ-035 i_Enable=0 at VS rise -> no transmission, o_Capture_En stays 1; 256 frames with enable -> o_Frame_Count wraps to 0.
REQ-036 VS falls before last byte sent -> DRAIN exits to IDLE one cycle after entry; second VS rise mid-SEND ignored.

Source files
------------

// File: rtl/frame_tx_sequencer_if.sv
// Byte-stream and frame-buffer read port between the sequencer and its peers.
// Signal names are from the sequencer's point of view.
interface frame_tx_sequencer_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] o_Mem_Addr;
    logic [7:0]        i_Mem_Data;
    logic [7:0]        o_Tx_Data;
    logic              o_Tx_Valid;
    logic              i_Tx_Ready;

    modport master (
        output o_Mem_Addr, o_Tx_Data, o_Tx_Valid,
        input  i_Mem_Data, i_Tx_Ready
    );

    modport slave (
        input  o_Mem_Addr, o_Tx_Data, o_Tx_Valid,
        output i_Mem_Data, i_Tx_Ready
    );
endinterface

// File: rtl/frame_tx_sequencer.sv
// Sends one captured frame (sync header + payload) to a UART per camera VS pulse.
//   state | meaning
//   IDLE  | camera may write the buffer, wait for VS rise with enable
//   GUARD | settle delay after VS rise
//   SYNC  | offer SYNC_LEN header bytes
//   FETCH | two cycles: present address, then latch read data
//   SEND  | offer payload byte until accepted
//   GAP   | idle spacing after an accepted payload byte
//   DRAIN | frame finished, wait for VS fall
module frame_tx_sequencer #(
    parameter int         ADDR_W          = 15,
    parameter int         BYTES_PER_FRAME = 6144,
    parameter int         GUARD_CYCLES    = 62500,
    parameter int         GAP_CYCLES      = 0,
    parameter int         SYNC_LEN        = 2,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
    input  logic                  Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_VS,
    input  logic                  i_Enable,
    frame_tx_sequencer_if.master  bus,
    output logic                  o_Capture_En,
    output logic                  o_Busy,
    output logic                  o_Frame_Done,
    output logic [7:0]            o_Frame_Count
);
    localparam int CNT_MAX = (GUARD_CYCLES > GAP_CYCLES) ? GUARD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  GUARD_LAST = (GUARD_CYCLES > 1) ? CNT_W'(GUARD_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0]  GAP_LAST   = (GAP_CYCLES > 1) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(BYTES_PER_FRAME - 1);
    localparam logic [2:0]        SYNC_LAST  = (SYNC_LEN > 0) ? 3'(SYNC_LEN - 1) : 3'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_GUARD, S_SYNC, S_FETCH, S_SEND, S_GAP, S_DRAIN
    } state_t;

    state_t            r_state, w_next;
    logic              r_vs_meta, r_vs_sync, r_vs_prev, r_vs_fall_seen;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_sync_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic              r_fetch_wait;
    logic              r_frame_done;
    logic [7:0]        r_frame_count;

    logic w_vs_rise, w_vs_fall, w_xfer, w_last_byte, w_entering_drain;

    assign w_vs_rise        = r_vs_sync & ~r_vs_prev;
    assign w_vs_fall        = ~r_vs_sync & r_vs_prev;
    assign w_xfer           = r_tx_valid & bus.i_Tx_Ready;
    assign w_last_byte      = (r_addr == ADDR_LAST);
    assign w_entering_drain = (w_next == S_DRAIN) && (r_state != S_DRAIN);

    always_ff @(posedge Clk) begin
        if (!i_Rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_vs_rise && i_Enable) w_next = S_GUARD;
            S_GUARD: if (r_cnt == GUARD_LAST) w_next = (SYNC_LEN > 0) ? S_SYNC : S_FETCH;
            S_SYNC:  if (w_xfer && r_sync_cnt == SYNC_LAST) w_next = S_FETCH;
            S_FETCH: if (r_fetch_wait) w_next = S_SEND;
            S_SEND: begin
                if (w_xfer) begin
                    if (w_last_byte)         w_next = S_DRAIN;
                    else if (GAP_CYCLES > 0) w_next = S_GAP;
                    else                     w_next = S_FETCH;
                end
            end
            S_GAP:   if (r_cnt == GAP_LAST) w_next = S_FETCH;
            S_DRAIN: if (r_vs_fall_seen || w_vs_fall) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_Capture_En = 1'b0;
        o_Busy       = 1'b1;
        if (r_state == S_IDLE) begin
            o_Capture_En = 1'b1;
            o_Busy       = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!i_Rst_n) begin
            r_vs_meta      <= 1'b0;
            r_vs_sync      <= 1'b0;
            r_vs_prev      <= 1'b0;
            r_vs_fall_seen <= 1'b0;
            r_cnt          <= '0;
            r_sync_cnt     <= '0;
            r_addr         <= '0;
            r_tx_data      <= '0;
            r_tx_valid     <= 1'b0;
            r_fetch_wait   <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_count  <= '0;
        end else begin
            r_vs_meta    <= i_VS;
            r_vs_sync    <= r_vs_meta;
            r_vs_prev    <= r_vs_sync;
            r_frame_done <= w_entering_drain;
            if (w_entering_drain) r_frame_count <= r_frame_count + 8'd1;

            // A fall seen mid-frame lets DRAIN leave without waiting for another edge
            if (r_state == S_IDLE) r_vs_fall_seen <= 1'b0;
            else if (w_vs_fall)    r_vs_fall_seen <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_cnt      <= '0;
                    r_sync_cnt <= '0;
                    r_addr     <= '0;
                end
                S_GUARD: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == GUARD_LAST && SYNC_LEN > 0) begin
                        r_tx_data  <= SYNC_BYTE;
                        r_tx_valid <= 1'b1;
                    end
                end
                S_SYNC: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_sync_cnt <= r_sync_cnt + 3'd1;
                    end else if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_fetch_wait <= ~r_fetch_wait;
                    if (r_fetch_wait) begin
                        r_tx_data  <= bus.i_Mem_Data;
                        r_tx_valid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_tx_valid <= 1'b0;
                        r_cnt      <= '0;
                        r_addr     <= w_last_byte ? '0 : r_addr + 1'b1;
                    end
                end
                S_GAP:   r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.o_Mem_Addr = r_addr;
    assign bus.o_Tx_Data  = r_tx_data;
    assign bus.o_Tx_Valid = r_tx_valid;
    assign o_Frame_Done   = r_frame_done;
    assign o_Frame_Count  = r_frame_count;
endmodule

// File: tb/tb_frame_tx_sequencer.sv
// Randomized scoreboard bench for frame_tx_sequencer: expected bytes, addresses and
// inter-byte idle spacing are queued per frame and checked by an independent monitor.
module tb_frame_tx_sequencer;
    localparam int         ADDR_W = 4;
    localparam int         BYTES  = 4;
    localparam int         GUARD  = 10;
    localparam int         GAP    = 5;
    localparam int         SLEN   = 2;
    localparam logic [7:0] SBYTE  = 8'hA5;
    // Read data arrives one cycle after the address, so every byte costs two fetch cycles.
    localparam int         FETCH_LAT = 2;

    typedef struct {
        logic [7:0] data;
        int         gap;
        int         addr;
    } exp_t;

    logic       Clk;
    logic       rst_n, vs, en;
    logic       cap_en, busy, fdone;
    logic [7:0] fcount;

    frame_tx_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    frame_tx_sequencer #(
        .ADDR_W(ADDR_W), .BYTES_PER_FRAME(BYTES), .GUARD_CYCLES(GUARD),
        .GAP_CYCLES(GAP), .SYNC_LEN(SLEN), .SYNC_BYTE(SBYTE)
    ) dut (
        .Clk(Clk), .i_Rst_n(rst_n), .i_VS(vs), .i_Enable(en), .bus(bus),
        .o_Capture_En(cap_en), .o_Busy(busy), .o_Frame_Done(fdone), .o_Frame_Count(fcount)
    );

    logic [7:0] mem [16];
    exp_t       sb [$];
    int         checks = 0;
    int         errors = 0;
    int         exp_frames = 0;
    int         n_xfer = 0;
    bit         mon_en = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge Clk);
            bus.i_Mem_Data <= mem[bus.o_Mem_Addr];
        end
    end

    initial begin
        bus.i_Tx_Ready = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            bus.i_Tx_Ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: samples at the falling edge, pops expectations on every accepted byte.
    initial begin
        logic       pv, pr, pd_done;
        logic [7:0] pdata;
        int         exp_gap, low_run;
        exp_t       e;
        pv = 0; pr = 0; pd_done = 0; pdata = 0; exp_gap = -1; low_run = 0;
        forever begin
            @(negedge Clk);
            if (!mon_en) begin
                sb.delete();
                pv = 0; pr = 0; pd_done = 0; exp_gap = -1; low_run = 0;
            end else begin
                check(cap_en == !busy, "capture_vs_busy", cap_en, !busy);
                if (pv && !pr)
                    check(bus.o_Tx_Valid && bus.o_Tx_Data == pdata, "hold_stable",
                          bus.o_Tx_Data, pdata);
                if (pv && pr)
                    check(!bus.o_Tx_Valid, "valid_drop", bus.o_Tx_Valid, 0);
                if (bus.o_Tx_Valid && exp_gap >= 0) begin
                    check(low_run == exp_gap, "idle_gap", low_run, exp_gap);
                    exp_gap = -1;
                end
                if (!bus.o_Tx_Valid) low_run++;
                if (bus.o_Tx_Valid && bus.i_Tx_Ready) begin
                    n_xfer++;
                    if (sb.size() == 0) begin
                        check(1'b0, "unexpected_byte", bus.o_Tx_Data, -1);
                    end else begin
                        e = sb.pop_front();
                        check(bus.o_Tx_Data == e.data, "tx_data", bus.o_Tx_Data, e.data);
                        if (e.addr >= 0)
                            check(int'(bus.o_Mem_Addr) == e.addr, "mem_addr", bus.o_Mem_Addr, e.addr);
                        exp_gap = e.gap;
                        low_run = 0;
                    end
                end
                if (fdone) begin
                    check(fcount == 8'(exp_frames), "frame_count", fcount, 8'(exp_frames));
                    check(sb.size() == 0, "frame_complete", sb.size(), 0);
                end
                if (pd_done) check(!fdone, "done_pulse", fdone, 0);
                pv = bus.o_Tx_Valid; pr = bus.i_Tx_Ready; pdata = bus.o_Tx_Data; pd_done = fdone;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check(bus.o_Mem_Addr == 0, {tag, "_addr"}, bus.o_Mem_Addr, 0);
        check(bus.o_Tx_Valid == 0, {tag, "_valid"}, bus.o_Tx_Valid, 0);
        check(bus.o_Tx_Data == 0, {tag, "_data"}, bus.o_Tx_Data, 0);
        check(cap_en == 1, {tag, "_capture"}, cap_en, 1);
        check(busy == 0, {tag, "_busy"}, busy, 0);
        check(fdone == 0, {tag, "_done"}, fdone, 0);
        check(fcount == 0, {tag, "_count"}, fcount, 0);
    endtask

    // mode 0: VS held through the frame; 1: VS falls early plus a second pulse mid-frame;
    // 2: reset asserted while the third payload byte is offered.
    task automatic run_frame(input int mode);
        int         base, n;
        logic [7:0] seed;
        exp_t       e;
        seed = 8'($urandom);
        for (int i = 0; i < 16; i++) mem[i] = seed + 8'(37 * i);
        for (int k = 0; k < SLEN; k++) begin
            e.data = SBYTE; e.gap = (k < SLEN - 1) ? 1 : FETCH_LAT; e.addr = -1;
            sb.push_back(e);
        end
        for (int i = 0; i < BYTES; i++) begin
            e.data = mem[i]; e.gap = (i < BYTES - 1) ? GAP + FETCH_LAT : -1; e.addr = i;
            sb.push_back(e);
        end
        exp_frames++;
        base = n_xfer;
        check(cap_en == 1 && busy == 0, "idle_before_frame", cap_en, 1);

        vs = 1'b1;
        n = 0;
        do begin tick(); n++; end while (cap_en && n < 8);
        check(n >= 3 && n <= 4, "capture_drop_latency", n, 3);

        n = 0;
        do begin
            tick(); n++;
            if (mode == 1 && n == 3) vs = 1'b0;
        end while (!bus.o_Tx_Valid && n < 100);
        check(n == GUARD, "guard_length", n, GUARD);

        if (mode == 2) begin
            n = 0;
            while (!((n_xfer - base) == SLEN + 2 && bus.o_Tx_Valid) && n < 500) begin tick(); n++; end
            check(n < 500, "wait_third_payload", n, 0);
            mon_en = 0;
            rst_n = 1'b0;
            vs = 1'b0;
            tick();
            check_reset_outputs("midframe_reset");
            exp_frames = 0;
            rst_n = 1'b1;
            tick();
            mon_en = 1;
            tick();
            return;
        end

        if (mode == 1) begin
            n = 0;
            while (!((n_xfer - base) == SLEN + 1 && bus.o_Tx_Valid) && n < 500) begin tick(); n++; end
            check(n < 500, "wait_second_payload", n, 0);
            vs = 1'b1;
            repeat (5) tick();
            vs = 1'b0;
        end

        n = 0;
        while (!fdone && n < 1000) begin tick(); n++; end
        check(n < 1000, "wait_frame_done", n, 0);
        check(cap_en == 0 && busy == 1, "drain_busy", cap_en, 0);

        if (mode == 1) begin
            tick();
            check(cap_en == 1, "drain_early_exit", cap_en, 1);
            n = 0;
            repeat (30) begin tick(); if (!cap_en) n++; end
            check(n == 0, "second_rise_ignored", n, 0);
        end else begin
            repeat (3) tick();
            check(cap_en == 0, "drain_waits_vs_fall", cap_en, 0);
            vs = 1'b0;
            n = 0;
            do begin tick(); n++; end while (!cap_en && n < 8);
            check(n >= 3 && n <= 4, "drain_exit_latency", n, 3);
        end
        repeat (2) tick();
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; vs = 1'b0; en = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        mon_en = 1;
        tick();

        run_frame(0);

        en = 1'b0;
        vs = 1'b1;
        bad = 0;
        repeat (6) begin tick(); if (!cap_en || busy) bad++; end
        vs = 1'b0;
        repeat (40) begin tick(); if (!cap_en || busy) bad++; end
        check(bad == 0, "enable_low_blocks", bad, 0);
        en = 1'b1;

        run_frame(1);
        run_frame(2);
        run_frame(0);
        check(fcount == 1, "count_after_reset_frame", fcount, 1);

        repeat (255) run_frame(0);
        check(fcount == 0, "count_wrap", fcount, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout actual=%0d required=%0d", checks, 0);
        $fatal(1);
    end
endmodule
